// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU bridge: FSM state encoding and the
// opcode values understood by the companion ALU.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, drives the
// external combinational ALU, and returns the result as one TX byte.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NBIT_DATA = 8,
    parameter int NBIT_OP   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 tx_done_tick,
    input  logic [NBIT_DATA-1:0] alu_result,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic                 tx_start,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 busy,
    output logic                 rx_overrun
);

    state_t state, state_next;

    logic [NBIT_DATA-1:0] alu_a_next, alu_b_next, tx_data_next;
    logic [NBIT_OP-1:0]   alu_op_next;
    logic                 tx_start_next, busy_next, rx_overrun_next;
    logic                 in_tx_phase;

    assign in_tx_phase = (state == SEND) || (state == WAIT_TX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_A;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (rx_done_tick) state_next = WAIT_B;
            WAIT_B:  if (rx_done_tick) state_next = WAIT_OP;
            WAIT_OP: if (rx_done_tick) state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (tx_done_tick) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Next values for every registered output; busy follows the next state so
    // it stays aligned with the state register.
    always_comb begin
        alu_a_next      = alu_a;
        alu_b_next      = alu_b;
        alu_op_next     = alu_op;
        tx_data_next    = tx_data;
        tx_start_next   = 1'b0;
        busy_next       = (state_next == SEND) || (state_next == WAIT_TX);
        rx_overrun_next = rx_overrun | (rx_done_tick & in_tx_phase);
        case (state)
            WAIT_A:  if (rx_done_tick) alu_a_next = rx_data;
            WAIT_B:  if (rx_done_tick) alu_b_next = rx_data;
            WAIT_OP: if (rx_done_tick) alu_op_next = rx_data[NBIT_OP-1:0];
            SEND: begin
                tx_data_next  = alu_result;
                tx_start_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            alu_a      <= alu_a_next;
            alu_b      <= alu_b_next;
            alu_op     <= alu_op_next;
            tx_data    <= tx_data_next;
            tx_start   <= tx_start_next;
            busy       <= busy_next;
            rx_overrun <= rx_overrun_next;
        end
    end

endmodule
